// File: rtl/exec_unit_mc.sv
// exec_unit_mc: RV32I-style execute stage with iterative M-extension multiply/divide.
// Valid/ready handshake on both sides; ALU ops take 1 cycle, mul/div take XLEN+2.
module exec_unit_mc #(
    parameter int XLEN     = 32,
    parameter int ENABLE_M = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] in1,
    input  logic [XLEN-1:0] in2,
    input  logic [XLEN-1:0] imm,
    input  logic            alusrc,
    input  logic [1:0]      aluop,
    input  logic [9:0]      funct,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] aluout,
    output logic            zero,
    output logic            busy,
    output logic [1:0]      dbg_state
);
    localparam int SW = $clog2(XLEN);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MUL  = 2'd1;
    localparam logic [1:0] S_DIV  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;
    localparam logic [SW-1:0]   LAST     = SW'(XLEN - 1);
    localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

    // Handshake: an op transfers on a rising edge where in_valid && in_ready; a result
    // transfers on a rising edge where out_valid && out_ready, and is held until then.
    logic [1:0]      r_state;
    logic [SW-1:0]   r_cnt;
    logic [XLEN-1:0] r_hi, r_lo, r_opnd;
    logic [2:0]      r_fn3;
    logic            r_neg_q, r_neg_r;
    logic            r_out_valid, r_zero;
    logic [XLEN-1:0] r_aluout;

    logic [XLEN-1:0]        w_b, w_res, w_div_special, w_amag, w_bmag, w_quo, w_rem, w_mc_res;
    logic signed [XLEN-1:0] w_sra;
    logic [2:0]             w_f3;
    logic [6:0]             w_f7;
    logic [SW-1:0]          w_shamt;
    logic                   w_accept, w_is_m, w_iter, w_zf;
    logic                   w_div_zero, w_div_ovf, w_a_signed, w_b_signed, w_sa, w_sb;
    logic [XLEN:0]          w_msum, w_dshift, w_ddiff;
    logic                   w_dge;
    logic [2*XLEN-1:0]      w_prod, w_prod_s;

    assign w_b        = alusrc ? imm : in2;
    assign w_f3       = funct[2:0];
    assign w_f7       = funct[9:3];
    assign w_shamt    = w_b[SW-1:0];
    assign w_sra      = $signed(in1) >>> w_shamt;
    assign in_ready   = (r_state == S_IDLE) && (!r_out_valid || out_ready);
    assign w_accept   = in_valid && in_ready;
    assign w_is_m     = (aluop == 2'd2) && (w_f7 == 7'b0000001);
    assign w_div_zero = (w_b == '0);
    assign w_div_ovf  = !w_f3[0] && (in1 == MOST_NEG) && (w_b == '1);
    assign w_iter     = w_is_m && (ENABLE_M != 0) && !(w_f3[2] && (w_div_zero || w_div_ovf));

    // Division corner cases resolve immediately instead of iterating.
    assign w_div_special = w_div_zero ? (w_f3[1] ? in1 : '1) : (w_f3[1] ? '0 : in1);

    // Signedness per op: mulh/mulhsu/div/rem treat rs1 as signed; mulh/div/rem also rs2.
    assign w_a_signed = (w_f3 == 3'd1) || (w_f3 == 3'd2) || (w_f3 == 3'd4) || (w_f3 == 3'd6);
    assign w_b_signed = (w_f3 == 3'd1) || (w_f3 == 3'd4) || (w_f3 == 3'd6);
    assign w_sa       = w_a_signed && in1[XLEN-1];
    assign w_sb       = w_b_signed && w_b[XLEN-1];
    assign w_amag     = w_sa ? -in1 : in1;
    assign w_bmag     = w_sb ? -w_b : w_b;

    always_comb begin
        w_res = '0;
        w_zf  = 1'b0;
        case (aluop)
            2'd0: w_res = in1 + w_b;
            2'd1: begin
                w_res = in1 - w_b;
                case (w_f3)
                    3'd0:    w_zf = (in1 == w_b);
                    3'd1:    w_zf = (in1 != w_b);
                    3'd4:    w_zf = ($signed(in1) < $signed(w_b));
                    3'd5:    w_zf = ($signed(in1) >= $signed(w_b));
                    3'd6:    w_zf = (in1 < w_b);
                    3'd7:    w_zf = (in1 >= w_b);
                    default: w_zf = 1'b0;
                endcase
            end
            default: begin
                case (w_f3)
                    3'd0:    w_res = (aluop == 2'd2 && w_f7[5]) ? in1 - w_b : in1 + w_b;
                    3'd1:    w_res = in1 << w_shamt;
                    3'd2:    w_res = {{(XLEN-1){1'b0}}, $signed(in1) < $signed(w_b)};
                    3'd3:    w_res = {{(XLEN-1){1'b0}}, in1 < w_b};
                    3'd4:    w_res = in1 ^ w_b;
                    3'd5:    w_res = w_f7[5] ? w_sra : in1 >> w_shamt;
                    3'd6:    w_res = in1 | w_b;
                    default: w_res = in1 & w_b;
                endcase
                if (w_is_m) w_res = (ENABLE_M != 0) ? w_div_special : '0;
            end
        endcase
        if (aluop != 2'd1) w_zf = (w_res == '0);
    end

    // Multiply: {r_hi,r_lo} holds partial product with multiplier in the low half.
    assign w_msum = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_opnd} : '0);
    // Divide: r_hi is partial remainder, r_lo shifts dividend out and quotient in.
    assign w_dshift = {r_hi, r_lo[XLEN-1]};
    assign w_dge    = (w_dshift >= {1'b0, r_opnd});
    assign w_ddiff  = w_dshift - {1'b0, r_opnd};

    assign w_prod   = {r_hi, r_lo};
    assign w_prod_s = r_neg_q ? -w_prod : w_prod;
    assign w_quo    = r_neg_q ? -r_lo : r_lo;
    assign w_rem    = r_neg_r ? -r_hi : r_hi;
    assign w_mc_res = r_fn3[2] ? (r_fn3[1] ? w_rem : w_quo)
                               : ((r_fn3 == 3'd0) ? w_prod_s[XLEN-1:0] : w_prod_s[2*XLEN-1:XLEN]);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_hi        <= '0;
            r_lo        <= '0;
            r_opnd      <= '0;
            r_fn3       <= 3'd0;
            r_neg_q     <= 1'b0;
            r_neg_r     <= 1'b0;
            r_out_valid <= 1'b0;
            r_aluout    <= '0;
            r_zero      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_fn3 <= w_f3;
                        if (w_iter) begin
                            r_state     <= w_f3[2] ? S_DIV : S_MUL;
                            r_cnt       <= '0;
                            r_out_valid <= 1'b0;
                            r_neg_q     <= w_sa ^ w_sb;
                            r_neg_r     <= w_sa;
                            r_hi        <= '0;
                            r_lo        <= w_f3[2] ? w_amag : w_bmag;
                            r_opnd      <= w_f3[2] ? w_bmag : w_amag;
                        end else begin
                            r_out_valid <= 1'b1;
                            r_aluout    <= w_res;
                            r_zero      <= w_zf;
                        end
                    end else if (out_ready) begin
                        r_out_valid <= 1'b0;
                    end
                end
                S_MUL, S_DIV: begin
                    if (r_state == S_MUL) begin
                        {r_hi, r_lo} <= {w_msum, r_lo[XLEN-1:1]};
                    end else begin
                        r_hi <= w_dge ? w_ddiff[XLEN-1:0] : w_dshift[XLEN-1:0];
                        r_lo <= {r_lo[XLEN-2:0], w_dge};
                    end
                    if (r_cnt == LAST) begin
                        r_state <= S_DONE;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + SW'(1);
                    end
                end
                default: begin
                    r_aluout    <= w_mc_res;
                    r_zero      <= (w_mc_res == '0);
                    r_out_valid <= 1'b1;
                    r_state     <= S_IDLE;
                end
            endcase
        end
    end

    assign out_valid = r_out_valid;
    assign aluout    = r_aluout;
    assign zero      = r_zero;
    assign busy      = (r_state == S_MUL) || (r_state == S_DIV);
    assign dbg_state = r_state;
endmodule

// File: tb/tb_exec_unit_mc.sv
// Bench for exec_unit_mc: directed vector table, handshake/reset sequences,
// and random operations checked against an arithmetic reference model.
module tb_exec_unit_mc;
    localparam int XLEN = 32;
    localparam int MLAT = XLEN + 2;

    typedef struct {
        logic [XLEN-1:0] in1;
        logic [XLEN-1:0] in2;
        logic [XLEN-1:0] imm;
        logic            alusrc;
        logic [1:0]      aluop;
        logic [9:0]      funct;
        logic [XLEN-1:0] exp_out;
        logic            exp_zero;
        int              exp_lat;
    } vec_t;

    logic            clk = 1'b0;
    logic            rst;
    logic            in_valid, in_ready, alusrc, out_valid, out_ready, zero, busy;
    logic [XLEN-1:0] in1, in2, imm, aluout;
    logic [1:0]      aluop, dbg_state;
    logic [9:0]      funct;

    int              total = 0;
    int              bad = 0;
    logic [XLEN:0]   exp_q[$];
    vec_t            tbl[$];

    exec_unit_mc #(.XLEN(XLEN), .ENABLE_M(1)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in1(in1), .in2(in2), .imm(imm), .alusrc(alusrc), .aluop(aluop), .funct(funct),
        .out_valid(out_valid), .out_ready(out_ready), .aluout(aluout), .zero(zero),
        .busy(busy), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [31:0] i1, input logic [31:0] i2, input logic [31:0] im,
                                input logic src, input logic [1:0] op, input logic [9:0] fn,
                                input logic [31:0] eo, input logic ez, input int el);
        vec_t v;
        v.in1 = i1; v.in2 = i2; v.imm = im; v.alusrc = src; v.aluop = op; v.funct = fn;
        v.exp_out = eo; v.exp_zero = ez; v.exp_lat = el;
        return v;
    endfunction

    // Reference model: RISC-V semantics computed with plain integer arithmetic.
    function automatic void model(input vec_t v, output logic [31:0] r, output logic z, output int lat);
        logic [31:0] a, b;
        logic [2:0]  f3;
        logic [6:0]  f7;
        int          ia, ib;
        longint      p;
        logic [63:0] up;
        a = v.in1;
        b = v.alusrc ? v.imm : v.in2;
        f3 = v.funct[2:0];
        f7 = v.funct[9:3];
        ia = a;
        ib = b;
        r = '0;
        z = 1'b0;
        lat = 1;
        if (v.aluop == 2'd2 && f7 == 7'b0000001) begin
            if (f3 < 3'd4) begin
                lat = MLAT;
                up = {32'b0, a} * {32'b0, b};
                case (f3)
                    3'd0: r = up[31:0];
                    3'd1: begin p = longint'(ia) * longint'(ib); r = p[63:32]; end
                    3'd2: begin p = longint'(ia) * longint'({32'b0, b}); r = p[63:32]; end
                    default: r = up[63:32];
                endcase
            end else if (b == 32'd0) begin
                r = (f3 == 3'd6 || f3 == 3'd7) ? a : 32'hFFFF_FFFF;
            end else if ((f3 == 3'd4 || f3 == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                r = (f3 == 3'd6) ? 32'd0 : a;
            end else begin
                lat = MLAT;
                case (f3)
                    3'd4: r = ia / ib;
                    3'd5: r = a / b;
                    3'd6: r = ia % ib;
                    default: r = a % b;
                endcase
            end
            z = (r == 32'd0);
        end else if (v.aluop == 2'd1) begin
            r = a - b;
            case (f3)
                3'd0: z = (a == b);
                3'd1: z = (a != b);
                3'd4: z = (ia < ib);
                3'd5: z = (ia >= ib);
                3'd6: z = (a < b);
                3'd7: z = (a >= b);
                default: z = 1'b0;
            endcase
        end else begin
            if (v.aluop == 2'd0) r = a + b;
            else begin
                case (f3)
                    3'd0: r = (v.aluop == 2'd2 && f7[5]) ? a - b : a + b;
                    3'd1: r = a << b[4:0];
                    3'd2: r = (ia < ib) ? 32'd1 : 32'd0;
                    3'd3: r = (a < b) ? 32'd1 : 32'd0;
                    3'd4: r = a ^ b;
                    3'd5: r = f7[5] ? 32'(ia >>> b[4:0]) : a >> b[4:0];
                    3'd6: r = a | b;
                    default: r = a & b;
                endcase
            end
            z = (r == 32'd0);
        end
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0: return 32'd0;
            1: return 32'd1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'h7FFF_FFFF;
            default: return $urandom();
        endcase
    endfunction

    // Driver + monitor for one op: accept, wait for result with a cycle budget, check, retire.
    task automatic run_op(input vec_t v, input string tag);
        logic [XLEN:0] exp;
        int lat, busy_n, rdy_n;
        exp_q.push_back({v.exp_zero, v.exp_out});
        in1 = v.in1; in2 = v.in2; imm = v.imm; alusrc = v.alusrc;
        aluop = v.aluop; funct = v.funct; in_valid = 1'b1;
        chk({tag, "/in_ready"}, 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1; busy_n = 0; rdy_n = 0;
        while (!out_valid && lat < 200) begin
            if (busy) busy_n++;
            if (in_ready) rdy_n++;
            @(posedge clk); #1;
            lat++;
        end
        exp = exp_q.pop_front();
        chk({tag, "/out_valid"}, 32'(out_valid), 32'd1);
        chk({tag, "/latency"}, 32'(lat), 32'(v.exp_lat));
        chk({tag, "/aluout"}, aluout, exp[XLEN-1:0]);
        chk({tag, "/zero"}, 32'(zero), 32'(exp[XLEN]));
        chk({tag, "/busy_cycles"}, 32'(busy_n), 32'((v.exp_lat > 1) ? v.exp_lat - 2 : 0));
        chk({tag, "/stall_in_ready"}, 32'(rdy_n), 32'd0);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk({tag, "/retired"}, 32'(out_valid), 32'd0);
    endtask

    initial begin
        logic [1:0] idle_code;
        int         nv;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        in1 = '0; in2 = '0; imm = '0; alusrc = 1'b0; aluop = 2'd0; funct = 10'd0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        chk("rst/out_valid", 32'(out_valid), 32'd0);
        chk("rst/aluout", aluout, 32'd0);
        chk("rst/zero", 32'(zero), 32'd0);
        chk("rst/busy", 32'(busy), 32'd0);
        chk("rst/in_ready", 32'(in_ready), 32'd1);
        idle_code = dbg_state;
        @(posedge clk); #1;

        tbl.push_back(mk(32'd5, 32'd7, 32'd0, 1'b0, 2'd2, {7'b0100000, 3'd0}, 32'hFFFF_FFFE, 1'b0, 1));
        tbl.push_back(mk(32'h8000_0000, 32'd0, 32'd4, 1'b1, 2'd3, {7'b0100000, 3'd5}, 32'hF800_0000, 1'b0, 1));
        tbl.push_back(mk(32'h8000_0000, 32'd0, 32'd4, 1'b1, 2'd3, {7'b0000000, 3'd5}, 32'h0800_0000, 1'b0, 1));
        tbl.push_back(mk(32'h8000_0000, 32'd1, 32'd0, 1'b0, 2'd1, {7'b0, 3'd4}, 32'h7FFF_FFFF, 1'b1, 1));
        tbl.push_back(mk(32'h8000_0000, 32'd1, 32'd0, 1'b0, 2'd1, {7'b0, 3'd6}, 32'h7FFF_FFFF, 1'b0, 1));
        tbl.push_back(mk(32'hFFFF_FFFD, 32'd7, 32'd0, 1'b0, 2'd2, {7'b0000001, 3'd1}, 32'hFFFF_FFFF, 1'b0, MLAT));
        tbl.push_back(mk(32'hFFFF_FFFD, 32'd7, 32'd0, 1'b0, 2'd2, {7'b0000001, 3'd0}, 32'hFFFF_FFEB, 1'b0, MLAT));
        tbl.push_back(mk(32'd7, 32'd0, 32'd0, 1'b0, 2'd2, {7'b0000001, 3'd4}, 32'hFFFF_FFFF, 1'b0, 1));
        tbl.push_back(mk(32'd7, 32'd0, 32'd0, 1'b0, 2'd2, {7'b0000001, 3'd6}, 32'd7, 1'b0, 1));
        tbl.push_back(mk(32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1'b0, 2'd2, {7'b0000001, 3'd4}, 32'h8000_0000, 1'b0, 1));
        tbl.push_back(mk(32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1'b0, 2'd2, {7'b0000001, 3'd6}, 32'd0, 1'b1, 1));
        tbl.push_back(mk(32'd10, 32'd0, 32'hFFFF_FFF6, 1'b1, 2'd0, 10'd0, 32'd0, 1'b1, 1));
        tbl.push_back(mk(32'd5, 32'd5, 32'd0, 1'b0, 2'd1, {7'b0, 3'd0}, 32'd0, 1'b1, 1));
        tbl.push_back(mk(32'd5, 32'd5, 32'd0, 1'b0, 2'd1, {7'b0, 3'd2}, 32'd0, 1'b0, 1));
        tbl.push_back(mk(32'd3, 32'd0, 32'd4, 1'b1, 2'd3, {7'b0100000, 3'd0}, 32'd7, 1'b0, 1));
        tbl.push_back(mk(32'd100, 32'd7, 32'd0, 1'b0, 2'd2, {7'b0000001, 3'd5}, 32'd14, 1'b0, MLAT));
        tbl.push_back(mk(32'd100, 32'd7, 32'd0, 1'b0, 2'd2, {7'b0000001, 3'd7}, 32'd2, 1'b0, MLAT));
        tbl.push_back(mk(32'hFFFF_FFF9, 32'd2, 32'd0, 1'b0, 2'd2, {7'b0000001, 3'd4}, 32'hFFFF_FFFD, 1'b0, MLAT));
        tbl.push_back(mk(32'hFFFF_FFF9, 32'd2, 32'd0, 1'b0, 2'd2, {7'b0000001, 3'd6}, 32'hFFFF_FFFF, 1'b0, MLAT));
        tbl.push_back(mk(32'd1, 32'd33, 32'd0, 1'b0, 2'd2, {7'b0, 3'd1}, 32'd2, 1'b0, 1));
        tbl.push_back(mk(32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, 2'd2, {7'b0, 3'd2}, 32'd1, 1'b0, 1));
        tbl.push_back(mk(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 1'b0, 2'd2, {7'b0000001, 3'd3}, 32'hFFFF_FFFE, 1'b0, MLAT));
        tbl.push_back(mk(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 1'b0, 2'd2, {7'b0000001, 3'd2}, 32'hFFFF_FFFF, 1'b0, MLAT));
        tbl.push_back(mk(32'd5, 32'd0, 32'd0, 1'b0, 2'd2, {7'b0000001, 3'd7}, 32'd5, 1'b0, 1));
        tbl.push_back(mk(32'd5, 32'd7, 32'd0, 1'b0, 2'd2, {7'b1111111, 3'd0}, 32'hFFFF_FFFE, 1'b0, 1));
        tbl.push_back(mk(32'hF0F0_F0F0, 32'd0, 32'h0FF0_0FF0, 1'b1, 2'd3, {7'b0, 3'd4}, 32'hFF00_FF00, 1'b0, 1));
        tbl.push_back(mk(32'hF0F0_F0F0, 32'd0, 32'h0FF0_0FF0, 1'b1, 2'd3, {7'b0, 3'd6}, 32'hFFF0_FFF0, 1'b0, 1));
        tbl.push_back(mk(32'hF0F0_F0F0, 32'd0, 32'h0FF0_0FF0, 1'b1, 2'd3, {7'b0, 3'd7}, 32'h00F0_00F0, 1'b0, 1));
        foreach (tbl[i]) run_op(tbl[i], $sformatf("vec%0d", i));

        // Backpressure: result held for 5 cycles while another op waits, then same-cycle retire+accept.
        in1 = 32'd1; in2 = 32'd2; alusrc = 1'b0; aluop = 2'd0; funct = 10'd0; in_valid = 1'b1;
        @(posedge clk); #1;
        in1 = 32'd40; in2 = 32'd2;
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("bp%0d/out_valid", k), 32'(out_valid), 32'd1);
            chk($sformatf("bp%0d/aluout", k), aluout, 32'd3);
            chk($sformatf("bp%0d/in_ready", k), 32'(in_ready), 32'd0);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        #1;
        chk("b2b/in_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0; out_ready = 1'b0;
        chk("b2b/out_valid", 32'(out_valid), 32'd1);
        chk("b2b/aluout", aluout, 32'd42);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("b2b/retired", 32'(out_valid), 32'd0);

        // Reset in the middle of a divide: nothing may come out afterwards.
        in1 = 32'd100; in2 = 32'd7; aluop = 2'd2; funct = {7'b0000001, 3'd5}; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        chk("mid/busy_before", 32'(busy), 32'd1);
        #1 rst = 1'b1;
        #1;
        chk("mid/out_valid", 32'(out_valid), 32'd0);
        chk("mid/busy", 32'(busy), 32'd0);
        chk("mid/aluout", aluout, 32'd0);
        chk("mid/state", 32'(dbg_state), 32'(idle_code));
        @(posedge clk); #1 rst = 1'b0;
        nv = 0;
        for (int k = 0; k < MLAT + 6; k++) begin
            if (out_valid) nv++;
            @(posedge clk); #1;
        end
        chk("mid/discarded", 32'(nv), 32'd0);
        run_op(mk(32'd20, 32'd22, 32'd0, 1'b0, 2'd0, 10'd0, 32'd42, 1'b0, 1), "post_rst_add");

        // Random ops against the reference model.
        for (int i = 0; i < 160; i++) begin
            vec_t        v;
            logic [6:0]  f7;
            logic [31:0] r;
            logic        z;
            int          l;
            v.in1 = pick(); v.in2 = pick(); v.imm = pick();
            v.alusrc = 1'($urandom_range(0, 1));
            v.aluop = 2'($urandom_range(0, 3));
            case ($urandom_range(0, 3))
                0: f7 = 7'b0000000;
                1: f7 = 7'b0100000;
                2: begin f7 = 7'b0000001; v.aluop = 2'd2; end
                default: f7 = 7'($urandom());
            endcase
            v.funct = {f7, 3'($urandom_range(0, 7))};
            model(v, r, z, l);
            v.exp_out = r; v.exp_zero = z; v.exp_lat = l;
            run_op(v, $sformatf("rnd%0d", i));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/exec_unit_mc.md
Name: exec_unit_mc

Overview:
- Parametrised, multi-cycle successor of the single-cycle RISC-V execute stage.
- Covers the full RV32I ALU and branch-compare function set at width XLEN.
- Adds the M extension: iterative multiply and iterative divide.
- Adds valid/ready handshakes on both sides, so the core pipeline stalls cleanly while a long operation runs.

Parameters:
- XLEN, 32, datapath width; power of two, minimum 8.
- ENABLE_M, 1, 1 = execute M-extension ops; 0 = M ops return 0 with 1-cycle latency.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  operation presented.
- in_ready  out  1  unit can accept an operation this cycle.
- in1  in  XLEN  rs1 value.
- in2  in  XLEN  rs2 value.
- imm  in  XLEN  sign-extended immediate.
- alusrc  in  1  1 = operand b is imm, 0 = operand b is in2.
- aluop  in  2  0 = add (load/store), 1 = branch compare, 2 = R-type, 3 = I-type.
- funct  in  10  {funct7[6:0], funct3[2:0]}.
- out_valid  out  1  result held on aluout/zero.
- out_ready  in  1  consumer takes the result.
- aluout  out  XLEN  result.
- zero  out  1  branch taken when aluop=1; otherwise (aluout==0).
- busy  out  1  a multiply/divide iteration is in progress.

Behaviour:
- Reset (async, any state):
  - state=IDLE, out_valid=0, aluout=0, zero=0, busy=0, iteration counter=0.
  - in_ready=1 immediately after reset deasserts.
  - An in-flight mul/div is discarded with no output.
- Handshake:
  - in_ready = (state==IDLE) && (!out_valid || out_ready).
  - Accept when in_valid && in_ready; all inputs are captured at accept.
  - out_valid stays high, with aluout/zero stable, until out_ready is sampled high.
  - Same-cycle out_ready plus a new accept is legal: the old result retires and the new op starts.
- Operand b = alusrc ? imm : in2.
- ALU ops, 1-cycle latency (out_valid the cycle after accept). For aluop 2/3, funct3 selects:
  - 0: add, or sub when aluop=2 and funct7[5]=1. I-type funct3=0 is always add.
  - 1: sll.
  - 2: slt (signed).
  - 3: sltu.
  - 4: xor.
  - 5: srl, or sra when funct7[5]=1.
  - 6: or.
  - 7: and.
  - Shift amount = b[log2(XLEN)-1:0].
  - All arithmetic is modulo 2^XLEN.
- aluop=0: add.
- aluop=1: aluout=a-b; zero is selected by funct3:
  - 0 eq, 1 ne, 4 lt signed, 5 ge signed, 6 ltu, 7 geu.
  - funct3 = 2 or 3 gives zero=0.
  - Signed compares are true comparisons, not just the sign of a-b, so they are correct on overflow.
- M ops are aluop=2 with funct7=0000001 and ENABLE_M=1.
- State machine: IDLE -> MUL or DIV on accept of an M op. After the last iteration -> DONE. DONE loads the output register and returns to IDLE (out_valid=1).
- MUL (funct3 0..3 = mul, mulh, mulhsu, mulhu):
  - Shift-add, one bit per cycle on operand magnitudes per signedness; 2*XLEN product; sign-corrected in DONE.
  - mul returns the low half; the others return the high half.
  - Latency XLEN+2 cycles from accept to out_valid.
- DIV (funct3 4..7 = div, divu, rem, remu):
  - Restoring division, one bit per cycle on magnitudes.
  - Quotient sign = sign(a) xor sign(b); remainder takes sign(a).
  - Latency XLEN+2 cycles.
- DIV special cases, resolved at accept with 1-cycle latency and no iteration:
  - Divide by zero: quotient = all ones, remainder = a.
  - Signed overflow (a = most-negative, b = -1): quotient = a, remainder = 0.
- busy=1 in the MUL and DIV states only.
- Unused encodings (M op with funct3 out of range cannot occur; funct7 neither 0, 0100000 nor 0000001): executed as the funct3 base op with funct7[5] honoured.

Test Plan:
- aluop=2, funct={0100000,000}, in1=5, in2=7 -> next cycle aluout=0xFFFFFFFE, zero=0, out_valid=1.
- aluop=3, alusrc=1, funct={0100000,101}, in1=0x80000000, imm=4 -> aluout=0xF8000000; the same op with funct7=0 -> 0x08000000.
- aluop=1, funct3=4, in1=0x80000000, in2=1 -> zero=1 (signed lt). funct3=6 with the same operands -> zero=0.
- mulh, in1=-3, in2=7 -> out_valid exactly 34 cycles after accept, aluout=0xFFFFFFFF. mul on the same operands -> 0xFFFFFFEB. in_ready=0 and busy=1 throughout.
- div in1=7, in2=0 -> 0xFFFFFFFF; rem on the same operands -> 7. div 0x80000000 by -1 -> 0x80000000. Each returns 1 cycle after accept.
- Backpressure and reset:
  - Hold out_ready=0 for 5 cycles after a result: aluout stable, in_ready=0, no new accept.
  - Assert rst mid-divide (cycle 10): out_valid=0 and busy=0 immediately.
  - After release, a new add completes normally.
